vga_scanout: RTL

- Display-side end of the pixel-write interface driven by the note-drawing blocks.
- Accepts pixel writes (x, y, colour, writeEn) into a 160x120x3-bit framebuffer.
- Continuously reads the framebuffer back out as 640x480@60 Hz VGA timing.
- Each framebuffer pixel is replicated as a 4x4 block on screen.
- Sits between the drawing FSMs and the board DAC pins.

---
 rtl/vga_scanout.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 160x120x3-bit framebuffer with a pixel-write port, scanned out as
// 640x480@60 Hz VGA timing with each framebuffer pixel shown as a 4x4 block.
// Sync, blank and colour all pass through the same two-tick pipeline so the pins stay aligned.
module vga_scanout #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       writeEn,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int FB_DEPTH = FB_W * FB_H;

    // Row base address; the 160-wide case uses a shift-add instead of a multiplier.
    function automatic logic [14:0] row_base(input logic [14:0] row);
        if (FB_W == 160) begin
            return (row << 7) + (row << 5);
        end else begin
            return row * FB_W[14:0];
        end
    endfunction

    logic        pix_en_q, pix_en_d;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;

    logic [14:0] rd_addr_q, rd_addr_d;
    logic        vis1_q, vis1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;

    logic [2:0]  rd_data_q, rd_data_d;
    logic        vis2_q, vis2_d;
    logic        hs2_q, hs2_d;
    logic        vs2_q, vs2_d;

    logic [2:0]  mem [FB_DEPTH];

    logic        visible;
    logic        hs_raw;
    logic        vs_raw;
    logic        wr_ok;
    logic [14:0] wr_addr;

    // Pixel-enable toggle and the raster counters, which step only on pix_en edges.
    always_comb begin
        pix_en_d = ~pix_en_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == 10'(H_TOTAL - 1)) begin
                hcount_d = '0;
                if (vcount_q == 10'(V_TOTAL - 1)) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Read pipeline: stage 0 latches address and raw timing, stage 1 reads memory and delays timing.
    always_comb begin
        visible   = (hcount_q < 10'(H_VIS)) && (vcount_q < 10'(V_VIS));
        hs_raw    = !((hcount_q >= 10'(HS_START)) && (hcount_q < 10'(HS_END)));
        vs_raw    = !((vcount_q >= 10'(VS_START)) && (vcount_q < 10'(VS_END)));
        rd_addr_d = rd_addr_q;
        vis1_d    = vis1_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        rd_data_d = rd_data_q;
        vis2_d    = vis2_q;
        hs2_d     = hs2_q;
        vs2_d     = vs2_q;
        if (pix_en_q) begin
            // Blanked positions read address 0 so the read never leaves the array.
            rd_addr_d = visible
                      ? row_base({5'd0, vcount_q >> SCALE_LOG2}) + {5'd0, hcount_q >> SCALE_LOG2}
                      : '0;
            vis1_d    = visible;
            hs1_d     = hs_raw;
            vs1_d     = vs_raw;
            rd_data_d = mem[rd_addr_q];
            vis2_d    = vis1_q;
            hs2_d     = hs1_q;
            vs2_d     = vs1_q;
        end
    end

    // State registers; reset forces counters to the frame origin and pins to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en_q  <= 1'b0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            rd_addr_q <= '0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rd_data_q <= '0;
            vis2_q    <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
        end else begin
            pix_en_q  <= pix_en_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            rd_addr_q <= rd_addr_d;
            vis1_q    <= vis1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            rd_data_q <= rd_data_d;
            vis2_q    <= vis2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
        end
    end

    // Write address decode; out-of-range coordinates are dropped.
    always_comb begin
        wr_ok   = writeEn && (x < 8'(FB_W)) && (y < 7'(FB_H));
        wr_addr = row_base({8'd0, y}) + {7'd0, x};
    end

    // Framebuffer write port, independent of pix_en and deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= colour;
        end
    end

    assign vga_clk     = pix_en_q;
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
    assign vga_blank_n = vis2_q;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = {8{rd_data_q[2] & vis2_q}};
    assign vga_g       = {8{rd_data_q[1] & vis2_q}};
    assign vga_b       = {8{rd_data_q[0] & vis2_q}};

endmodule
